// File: rtl/alu_pkg.sv
// Opcode encodings, flag bit positions and per-opcode decode helpers shared by the ALU scheduler.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_V = 2;
  localparam int FLG_W = 3;

  // The ALU leaves unselected flag outputs stale, so only masked bits may be captured.
  function automatic logic [FLG_W-1:0] op_flag_mask(input logic [3:0] op);
    logic [FLG_W-1:0] m;
    m = '0;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLG_Z] = 1'b1;
      OP_RED, OP_PADDSB, OP_LW, OP_SW: m = '0;
      default:                        m = '0;
    endcase
    return m;
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return (op > OP_SW);
  endfunction

endpackage

// File: rtl/alu_arb2.sv
// Two-way arbiter: round-robin or port-0 priority with aging for port 1.
// Grant is combinational from the valids; pointer and age move only on the registered accept feedback.
module alu_arb2 #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req_valid,
  input  logic [1:0] i_accept,
  output logic [1:0] o_grant
);

  localparam int AW = 4;
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

  logic          r_rr_ptr;  // port that wins the next contention in round-robin mode
  logic [AW-1:0] r_age;
  logic          w_pick1;

  always_comb begin
    w_pick1 = 1'b0;
    if (PRIO_MODE == 0) begin
      w_pick1 = r_rr_ptr;
    end else begin
      w_pick1 = (r_age == AGE_MAX);
    end
  end

  always_comb begin
    o_grant = 2'b00;
    case (i_req_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = w_pick1 ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
      r_age    <= '0;
    end else begin
      if (i_accept[0]) begin
        r_rr_ptr <= 1'b1;
      end else if (i_accept[1]) begin
        r_rr_ptr <= 1'b0;
      end

      if (!i_req_valid[1] || i_accept[1]) begin
        r_age <= '0;
      end else if (r_age != AGE_MAX) begin
        r_age <= r_age + AW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between the EX stage (port 0) and the debug engine (port 1); 1-cycle registered response,
// req_ready drops while the response slot is held. ALU_SCHED_PERF_EN adds grant/stall performance counters.
module alu_sched
  import alu_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  input  logic [15:0] req_a0,
  input  logic [15:0] req_a1,
  input  logic [15:0] req_b0,
  input  logic [15:0] req_b1,
  input  logic [3:0]  req_imm0,
  input  logic [3:0]  req_imm1,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_imm,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [15:0] perf_gnt0,
  output logic [15:0] perf_gnt1,
  output logic [15:0] perf_stall
`endif
);

  logic [1:0]       w_grant;
  logic [1:0]       w_accept;
  logic             w_slot_free;
  logic             w_ill;
  logic [FLG_W-1:0] w_fmask;
  logic [FLG_W-1:0] w_alu_flags;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [15:0]      r_rsp_data;
  logic             r_rsp_err;
  logic [FLG_W-1:0] r_flags;

  alu_arb2 #(
    .PRIO_MODE (PRIO_MODE),
    .MAX_WAIT  (MAX_WAIT)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_accept    (w_accept),
    .o_grant     (w_grant)
  );

  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign req_ready   = w_slot_free ? w_grant : 2'b00;
  assign w_accept    = req_valid & req_ready;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_imm = '0;
    alu_op  = '0;
    if (w_grant[0]) begin
      alu_a   = req_a0;
      alu_b   = req_b0;
      alu_imm = req_imm0;
      alu_op  = req_op0;
    end else if (w_grant[1]) begin
      alu_a   = req_a1;
      alu_b   = req_b1;
      alu_imm = req_imm1;
      alu_op  = req_op1;
    end
  end

  // alu_op carries the accepted port's opcode whenever an accept happens.
  assign w_ill   = op_illegal(alu_op);
  assign w_fmask = (w_accept[0] && !w_ill) ? op_flag_mask(alu_op) : '0;

  always_comb begin
    w_alu_flags        = '0;
    w_alu_flags[FLG_Z] = alu_z;
    w_alu_flags[FLG_N] = alu_n;
    w_alu_flags[FLG_V] = alu_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_flags     <= '0;
    end else begin
      if (|w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= w_accept[1];
        r_rsp_data  <= w_ill ? 16'h0000 : alu_out;
        r_rsp_err   <= w_ill;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      for (int k = 0; k < FLG_W; k++) begin
        if (w_fmask[k]) begin
          r_flags[k] <= w_alu_flags[k];
        end
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign flag_z    = r_flags[FLG_Z];
  assign flag_n    = r_flags[FLG_N];
  assign flag_v    = r_flags[FLG_V];

`ifdef ALU_SCHED_PERF_EN
  logic [15:0] r_perf_gnt0;
  logic [15:0] r_perf_gnt1;
  logic [15:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_gnt0  <= '0;
      r_perf_gnt1  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept[0]) r_perf_gnt0 <= r_perf_gnt0 + 16'd1;
      if (w_accept[1]) r_perf_gnt1 <= r_perf_gnt1 + 16'd1;
      if (|(req_valid & ~req_ready)) r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_gnt0  = r_perf_gnt0;
  assign perf_gnt1  = r_perf_gnt1;
  assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Randomized and directed checks of alu_sched against a transaction-level reference model.
module tb_alu_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op0, req_op1, req_imm0, req_imm1;
  logic [15:0] req_a0, req_a1, req_b0, req_b1;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_imm, alu_op;
  logic        alu_z, alu_n, alu_v;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic        flag_z, flag_n, flag_v;
  logic [2:0]  junk;
`ifdef ALU_SCHED_PERF_EN
  logic [15:0] perf_gnt0, perf_gnt1, perf_stall;
`endif

  // second instance: fixed priority with aging
  logic [1:0]  d1_req_valid, d1_req_ready;
  logic [15:0] d1_alu_a, d1_alu_b, d1_alu_out, d1_rsp_data;
  logic [3:0]  d1_alu_imm, d1_alu_op;
  logic        d1_rsp_valid, d1_rsp_ready, d1_rsp_id, d1_rsp_err, d1_fz, d1_fn, d1_fv;
`ifdef ALU_SCHED_PERF_EN
  logic [15:0] d1_pg0, d1_pg1, d1_pst;
`endif

  int n_chk = 0;
  int n_bad = 0;

  alu_sched #(.PRIO_MODE(0), .MAX_WAIT(7)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1), .req_imm0(req_imm0), .req_imm1(req_imm1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
`ifdef ALU_SCHED_PERF_EN
    , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_stall(perf_stall)
`endif
  );

  alu_sched #(.PRIO_MODE(1), .MAX_WAIT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(d1_req_valid), .req_ready(d1_req_ready),
    .req_op0(4'h0), .req_op1(4'h0), .req_a0(16'h1111), .req_a1(16'h2222),
    .req_b0(16'h0000), .req_b1(16'h0000), .req_imm0(4'h0), .req_imm1(4'h0),
    .alu_a(d1_alu_a), .alu_b(d1_alu_b), .alu_imm(d1_alu_imm), .alu_op(d1_alu_op),
    .alu_out(d1_alu_out), .alu_z(1'b0), .alu_n(1'b0), .alu_v(1'b0),
    .rsp_valid(d1_rsp_valid), .rsp_ready(d1_rsp_ready), .rsp_id(d1_rsp_id), .rsp_data(d1_rsp_data),
    .rsp_err(d1_rsp_err), .flag_z(d1_fz), .flag_n(d1_fn), .flag_v(d1_fv)
`ifdef ALU_SCHED_PERF_EN
    , .perf_gnt0(d1_pg0), .perf_gnt1(d1_pg1), .perf_stall(d1_pst)
`endif
  );

  assign d1_alu_out = d1_alu_a ^ d1_alu_b ^ {12'd0, d1_alu_imm} ^ {12'd0, d1_alu_op};

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s);
    logic [15:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a ^ b;
      4'd3:    r = {15'd0, ^a};
      4'd4:    r = a << s;
      4'd5:    r = $signed(a) >>> s;
      4'd6:    r = (a >> s) | (a << (16 - s));
      4'd7:    r = {a[15:8] + b[15:8], a[7:0] + b[7:0]};
      4'd8:    r = a + b;
      4'd9:    r = a + b;
      default: r = 16'hDEAD;
    endcase
    return r;
  endfunction

  function automatic logic ovf(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] r);
    if (op == 4'd0) return (a[15] == b[15]) && (r[15] != a[15]);
    if (op == 4'd1) return (a[15] != b[15]) && (r[15] != a[15]);
    return 1'b0;
  endfunction

  // Behavioural ALU: flags not meaningful for the opcode carry random stale values.
  always_comb begin
    alu_out = alu_fn(alu_op, alu_a, alu_b, alu_imm);
    alu_z   = junk[0];
    alu_n   = junk[1];
    alu_v   = junk[2];
    if (alu_op == 4'd0 || alu_op == 4'd1) begin
      alu_z = (alu_out == 16'd0);
      alu_n = alu_out[15];
      alu_v = ovf(alu_op, alu_a, alu_b, alu_out);
    end else if (alu_op == 4'd2 || alu_op == 4'd4 || alu_op == 4'd5 || alu_op == 4'd6) begin
      alu_z = (alu_out == 16'd0);
    end
  end

  // reference model state
  logic        m_rv, m_id, m_err, m_z, m_n, m_v;
  logic [15:0] m_data;
  int          m_last;
  int          m_g0, m_g1, m_st;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rv = 0; m_id = 0; m_err = 0; m_data = '0;
    m_z = 0; m_n = 0; m_v = 0;
    m_last = 1;
    m_g0 = 0; m_g1 = 0; m_st = 0;
  endtask

  // Called at posedge+1; applies one cycle of stimulus and checks before and after the edge.
  task automatic step(input logic [1:0] v, input logic rr,
                      input logic [3:0] o0, input logic [15:0] a0, input logic [15:0] b0, input logic [3:0] i0,
                      input logic [3:0] o1, input logic [15:0] a1, input logic [15:0] b1, input logic [3:0] i1);
    logic [1:0]  g, rdy;
    logic [3:0]  op;
    logic [15:0] r, ea;
    logic        free, p;
    req_valid = v; rsp_ready = rr;
    req_op0 = o0; req_a0 = a0; req_b0 = b0; req_imm0 = i0;
    req_op1 = o1; req_a1 = a1; req_b1 = b1; req_imm1 = i1;
    junk = 3'($urandom);
    #1;
    if (v == 2'b01)      g = 2'b01;
    else if (v == 2'b10) g = 2'b10;
    else if (v == 2'b11) g = (m_last == 0) ? 2'b10 : 2'b01;
    else                 g = 2'b00;
    free = !m_rv || rr;
    rdy  = free ? g : 2'b00;
    ea   = g[0] ? a0 : (g[1] ? a1 : 16'h0000);
    check_val("req_ready", 32'(req_ready), 32'(rdy));
    check_val("alu_a", 32'(alu_a), 32'(ea));
    if ((v & ~rdy) != 2'b00) m_st++;
    @(posedge clk);
    #1;
    if (rdy != 2'b00) begin
      p  = rdy[1];
      op = p ? o1 : o0;
      r  = p ? alu_fn(o1, a1, b1, i1) : alu_fn(o0, a0, b0, i0);
      m_rv = 1; m_id = p;
      m_err  = (op >= 4'd10);
      m_data = m_err ? 16'h0000 : r;
      if (!p) begin
        m_g0++;
        if (op == 4'd0 || op == 4'd1) begin
          m_z = (r == 0); m_n = r[15]; m_v = ovf(op, a0, b0, r);
        end else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) begin
          m_z = (r == 0);
        end
      end else begin
        m_g1++;
      end
      m_last = p ? 1 : 0;
    end else if (rr) begin
      m_rv = 0;
    end
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    if (m_rv) begin
      check_val("rsp_id", 32'(rsp_id), 32'(m_id));
      check_val("rsp_data", 32'(rsp_data), 32'(m_data));
      check_val("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    check_val("flags", 32'({flag_v, flag_n, flag_z}), 32'({m_v, m_n, m_z}));
`ifdef ALU_SCHED_PERF_EN
    check_val("perf_gnt0", 32'(perf_gnt0), 32'(m_g0[15:0]));
    check_val("perf_gnt1", 32'(perf_gnt1), 32'(m_g1[15:0]));
    check_val("perf_stall", 32'(perf_stall), 32'(m_st[15:0]));
`endif
  endtask

  task automatic idle(input logic rr);
    step(2'b00, rr, 4'd0, 16'd0, 16'd0, 4'd0, 4'd0, 16'd0, 16'd0, 4'd0);
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_valid"}, 32'(rsp_valid), 32'd0);
    check_val({tag, "_id"}, 32'(rsp_id), 32'd0);
    check_val({tag, "_data"}, 32'(rsp_data), 32'd0);
    check_val({tag, "_err"}, 32'(rsp_err), 32'd0);
    check_val({tag, "_flags"}, 32'({flag_v, flag_n, flag_z}), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq4;
  logic [4:0] seq5;

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1; junk = '0;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_a1 = '0; req_b0 = '0; req_b1 = '0;
    req_imm0 = '0; req_imm1 = '0;
    d1_req_valid = '0; d1_rsp_ready = 1'b1;
    model_reset();
    #13;
    check_zero("reset");
    check_val("reset_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD 0x7FFF + 1: signed overflow into negative
    step(2'b01, 1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'd0, 4'd0, 16'd0, 16'd0, 4'd0);
    check_val("add_data", 32'(rsp_data), 32'h8000);
    check_val("add_id", 32'(rsp_id), 32'd0);
    check_val("add_flags", 32'({flag_v, flag_n, flag_z}), 32'b110);

    // flag masking
    step(2'b01, 1'b1, 4'd1, 16'd5, 16'd5, 4'd0, 4'd0, 16'd0, 16'd0, 4'd0);
    check_val("sub_z", 32'(flag_z), 32'd1);
    step(2'b01, 1'b1, 4'd2, 16'h00F0, 16'h0F00, 4'd0, 4'd0, 16'd0, 16'd0, 4'd0);
    check_val("xor_flags", 32'({flag_v, flag_n, flag_z}), 32'b000);
    step(2'b10, 1'b1, 4'd0, 16'd0, 16'd0, 4'd0, 4'd1, 16'd3, 16'd3, 4'd0);
    check_val("p1_sub_flags", 32'({flag_v, flag_n, flag_z}), 32'b000);
    check_val("p1_sub_id", 32'(rsp_id), 32'd1);

    // hold a response under stall, then reset asynchronously
    step(2'b01, 1'b1, 4'd0, 16'h7FFF, 16'h0001, 4'd0, 4'd0, 16'd0, 16'd0, 4'd0);
    idle(1'b0);
    mid_reset();
    step(2'b01, 1'b1, 4'd0, 16'h1234, 16'h0001, 4'd0, 4'd0, 16'd0, 16'd0, 4'd0);
    check_val("post_rst_data", 32'(rsp_data), 32'h1235);
    idle(1'b1);

    // round-robin contention from a fresh pointer
    mid_reset();
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 1'b1, 4'd0, 16'(k), 16'd1, 4'd0, 4'd2, 16'(k), 16'hFFFF, 4'd0);
      seq4[k] = rsp_id;
    end
    check_val("rr_seq", 32'(seq4), 32'b1010);

    // backpressure: stall three cycles, then drain and refill on one edge
    step(2'b01, 1'b1, 4'd4, 16'h0003, 16'd0, 4'd3, 4'd0, 16'd0, 16'd0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      step(2'b11, 1'b0, 4'd5, 16'h8000, 16'd0, 4'd2, 4'd6, 16'h0001, 16'd0, 4'd1);
      check_val("bp_hold", 32'(rsp_data), 32'h0018);
    end
    step(2'b01, 1'b1, 4'd5, 16'h8000, 16'd0, 4'd2, 4'd0, 16'd0, 16'd0, 4'd0);
    check_val("bp_refill", 32'(rsp_data), 32'hE000);

    // illegal opcode from port 0
    step(2'b01, 1'b1, 4'd12, 16'h0001, 16'h0002, 4'd0, 4'd0, 16'd0, 16'd0, 4'd0);
    check_val("ill_err", 32'(rsp_err), 32'd1);
    check_val("ill_data", 32'(rsp_data), 32'd0);

    for (int k = 0; k < 400; k++) begin
      step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom),
           4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 4'($urandom));
    end
    idle(1'b1);

    // fixed priority with aging, MAX_WAIT=3
    mid_reset();
    d1_req_valid = 2'b11; d1_rsp_ready = 1'b1;
    #1 check_val("d1_ready0", 32'(d1_req_ready), 32'b01);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      seq5[k] = d1_rsp_id;
      check_val("d1_valid", 32'(d1_rsp_valid), 32'd1);
      check_val("d1_data", 32'(d1_rsp_data), d1_rsp_id ? 32'h2222 : 32'h1111);
    end
    check_val("age_seq", 32'(seq5), 32'b01000);
    check_val("d1_misc", 32'({d1_rsp_err, d1_fv, d1_fn, d1_fz}), 32'd0);
    d1_req_valid = 2'b00;

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
